// File: rtl/wb_stage_buf.sv
// Writeback stage buffer: accepts up to NLANE results per cycle into an in-order
// FIFO and retires up to NPORT of them per cycle to register-file write ports.
module wb_stage_buf #(
  parameter int NLANE = 2,
  parameter int NPORT = 1,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NLANE-1:0]                in_valid_i,
  input  logic [NLANE-1:0][4:0]           in_rd_i,
  input  logic [NLANE-1:0][XLEN-1:0]      in_data_i,
  output logic                            in_ready_o,
  output logic [NPORT-1:0]                rf_we_o,
  output logic [NPORT-1:0][4:0]           rf_waddr_o,
  output logic [NPORT-1:0][XLEN-1:0]      rf_wdata_o,
  output logic [31:0]                     pend_mask_o,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  logic                      accept;
  logic [NLANE-1:0]          keep;
  logic [NLANE-1:0][PW-1:0]  widx;
  logic [CW-1:0]             n_enq;
  logic [CW-1:0]             n_drain;
  logic [NPORT-1:0]          pv;
  logic [PW-1:0]             off;
  logic [31:0]               pend;

  // No credit for a same-cycle drain: readiness uses the registered count only.
  assign in_ready_o  = (int'(count_q) <= DEPTH - NLANE);
  assign occupancy_o = count_q;
  assign pend_mask_o = pend;

  // Compact surviving lanes (x0 targets dropped) into consecutive slots.
  always_comb begin
    accept = in_ready_o & (|in_valid_i);
    n_enq  = '0;
    keep   = '0;
    widx   = '0;
    for (int i = 0; i < NLANE; i++) begin
      keep[i] = accept && in_valid_i[i] && (in_rd_i[i] != 5'd0);
      widx[i] = wr_ptr_q + n_enq[PW-1:0];
      if (keep[i]) n_enq = n_enq + CW'(1);
    end
  end

  always_comb begin
    n_drain    = (count_q < CW'(NPORT)) ? count_q : CW'(NPORT);
    pv         = '0;
    rf_we_o    = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    for (int j = 0; j < NPORT; j++) begin
      pv[j] = (CW'(j) < count_q);
      if (pv[j]) begin
        rf_waddr_o[j] = rd_q[rd_ptr_q + PW'(j)];
        rf_wdata_o[j] = data_q[rd_ptr_q + PW'(j)];
      end
    end
    // Same-cycle WAW: an older port is masked when a younger one hits the same reg.
    for (int j = 0; j < NPORT; j++) begin
      rf_we_o[j] = pv[j];
      for (int k = j + 1; k < NPORT; k++)
        if (pv[k] && (rf_waddr_o[k] == rf_waddr_o[j])) rf_we_o[j] = 1'b0;
    end
  end

  always_comb begin
    pend = '0;
    off  = '0;
    for (int e = 0; e < DEPTH; e++) begin
      off = PW'(e) - rd_ptr_q;
      if (CW'(off) < count_q) pend[rd_q[e]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_comb begin
    count_d  = count_q + n_enq - n_drain;
    rd_ptr_d = rd_ptr_q + n_drain[PW-1:0];
    wr_ptr_d = wr_ptr_q + n_enq[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is derived from count and pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (keep[i]) begin
        rd_q[widx[i]]   <= in_rd_i[i];
        data_q[widx[i]] <= in_data_i[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: one instance with a single write port and
// one with two, checked against expected RF writes queued at stimulus time.
module tb_wb_stage_buf;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk, rst;
  int   vecs, errs;
  wr_t  qa[$];
  wr_t  qb[$];

  logic [1:0]        a_in_valid, b_in_valid;
  logic [1:0][4:0]   a_in_rd, b_in_rd;
  logic [1:0][31:0]  a_in_data, b_in_data;
  logic              a_in_ready, b_in_ready;
  logic [0:0]        a_rf_we;
  logic [0:0][4:0]   a_rf_waddr;
  logic [0:0][31:0]  a_rf_wdata;
  logic [1:0]        b_rf_we;
  logic [1:0][4:0]   b_rf_waddr;
  logic [1:0][31:0]  b_rf_wdata;
  logic [31:0]       a_pend, b_pend;
  logic [2:0]        a_occ, b_occ;

  wb_stage_buf #(.NLANE(2), .NPORT(1), .DEPTH(4), .XLEN(32)) u_a (
    .clk(clk), .rst(rst), .in_valid_i(a_in_valid), .in_rd_i(a_in_rd),
    .in_data_i(a_in_data), .in_ready_o(a_in_ready), .rf_we_o(a_rf_we),
    .rf_waddr_o(a_rf_waddr), .rf_wdata_o(a_rf_wdata), .pend_mask_o(a_pend),
    .occupancy_o(a_occ));

  wb_stage_buf #(.NLANE(2), .NPORT(2), .DEPTH(4), .XLEN(32)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(b_in_valid), .in_rd_i(b_in_rd),
    .in_data_i(b_in_data), .in_ready_o(b_in_ready), .rf_we_o(b_rf_we),
    .rf_waddr_o(b_rf_waddr), .rf_wdata_o(b_rf_wdata), .pend_mask_o(b_pend),
    .occupancy_o(b_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every RF write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (a_rf_we[0]) begin
        vecs++;
        if (qa.size() == 0) begin
          errs++;
          $display("FAIL a_write unexpected: got addr=%0d data=%h, expected none", a_rf_waddr[0], a_rf_wdata[0]);
        end else begin
          e = qa.pop_front();
          if (a_rf_waddr[0] !== e.a || a_rf_wdata[0] !== e.d) begin
            errs++;
            $display("FAIL a_write: got addr=%0d data=%h, expected addr=%0d data=%h", a_rf_waddr[0], a_rf_wdata[0], e.a, e.d);
          end
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (b_rf_we[j]) begin
          vecs++;
          if (qb.size() == 0) begin
            errs++;
            $display("FAIL b_write%0d unexpected: got addr=%0d data=%h, expected none", j, b_rf_waddr[j], b_rf_wdata[j]);
          end else begin
            e = qb.pop_front();
            if (b_rf_waddr[j] !== e.a || b_rf_wdata[j] !== e.d) begin
              errs++;
              $display("FAIL b_write%0d: got addr=%0d data=%h, expected addr=%0d data=%h", j, b_rf_waddr[j], b_rf_wdata[j], e.a, e.d);
            end
          end
        end
      end
    end
  end

  // Drive the single-port instance and queue what it should eventually write.
  task automatic drive_a(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    a_in_valid = {v1, v0};
    a_in_rd    = {r1, r0};
    a_in_data  = {d1, d0};
    if (a_in_ready && (v0 || v1)) begin
      if (v0 && r0 != 5'd0) qa.push_back('{a: r0, d: d0});
      if (v1 && r1 != 5'd0) qa.push_back('{a: r1, d: d1});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs += 4;
    if (a_rf_we !== 1'b0) begin errs++; $display("FAIL reset_we: got %b, expected 0", a_rf_we); end
    if (a_pend !== 32'h0) begin errs++; $display("FAIL reset_pend: got %h, expected 0", a_pend); end
    if (a_occ !== 3'd0) begin errs++; $display("FAIL reset_occ: got %0d, expected 0", a_occ); end
    if (a_in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b, expected 1", a_in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_pair();
    @(negedge clk); drive_a(1, 5, 32'hA, 1, 6, 32'hB);
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0);
    vecs += 4;
    if (a_rf_we !== 1'b1 || a_rf_waddr[0] !== 5'd5) begin errs++; $display("FAIL pair_c1_port: got we=%b addr=%0d, expected we=1 addr=5", a_rf_we, a_rf_waddr[0]); end
    if (a_rf_wdata[0] !== 32'hA) begin errs++; $display("FAIL pair_c1_data: got %h, expected a", a_rf_wdata[0]); end
    if (a_pend !== 32'h60) begin errs++; $display("FAIL pair_c1_pend: got %h, expected 60", a_pend); end
    if (a_occ !== 3'd2) begin errs++; $display("FAIL pair_c1_occ: got %0d, expected 2", a_occ); end
    @(negedge clk);
    vecs += 3;
    if (a_rf_waddr[0] !== 5'd6 || a_rf_wdata[0] !== 32'hB) begin errs++; $display("FAIL pair_c2_port: got addr=%0d data=%h, expected 6/b", a_rf_waddr[0], a_rf_wdata[0]); end
    if (a_pend !== 32'h40) begin errs++; $display("FAIL pair_c2_pend: got %h, expected 40", a_pend); end
    if (a_occ !== 3'd1) begin errs++; $display("FAIL pair_c2_occ: got %0d, expected 1", a_occ); end
    @(negedge clk);
    vecs += 2;
    if (a_rf_we !== 1'b0) begin errs++; $display("FAIL pair_c3_we: got %b, expected 0", a_rf_we); end
    if (a_pend !== 32'h0) begin errs++; $display("FAIL pair_c3_pend: got %h, expected 0", a_pend); end
  endtask

  task automatic test_x0_discard();
    @(negedge clk); drive_a(1, 0, 32'hFF, 1, 9, 32'h3);
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0);
    vecs += 3;
    if (a_occ !== 3'd1) begin errs++; $display("FAIL x0_occ: got %0d, expected 1", a_occ); end
    if (a_rf_we !== 1'b1 || a_rf_waddr[0] !== 5'd9 || a_rf_wdata[0] !== 32'h3) begin errs++; $display("FAIL x0_port: got we=%b addr=%0d data=%h, expected 1/9/3", a_rf_we, a_rf_waddr[0], a_rf_wdata[0]); end
    if (a_pend !== 32'h200) begin errs++; $display("FAIL x0_pend: got %h, expected 200", a_pend); end
    @(negedge clk);
    vecs++;
    if (a_rf_we !== 1'b0 || a_occ !== 3'd0) begin errs++; $display("FAIL x0_after: got we=%b occ=%0d, expected 0/0", a_rf_we, a_occ); end
  endtask

  task automatic test_back_pressure();
    int exp_occ[7] = '{0, 2, 3, 2, 3, 2, 3};
    logic exp_rdy[7] = '{1, 1, 0, 1, 0, 1, 0};
    int k = 0;
    int wait_cyc = 0;
    logic [4:0] r0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vecs += 2;
      if (a_occ !== 3'(exp_occ[c])) begin errs++; $display("FAIL bp_occ c%0d: got %0d, expected %0d", c, a_occ, exp_occ[c]); end
      if (a_in_ready !== exp_rdy[c]) begin errs++; $display("FAIL bp_ready c%0d: got %b, expected %b", c, a_in_ready, exp_rdy[c]); end
      r0 = 5'(1 + (2 * k) % 30);
      drive_a(1, r0, 32'h100 + 32'(2 * k), 1, r0 + 5'd1, 32'h101 + 32'(2 * k));
      if (a_in_ready) k++;
    end
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0);
    while (a_occ != 3'd0 && wait_cyc < 12) begin
      @(negedge clk);
      wait_cyc++;
    end
    vecs++;
    if (a_occ !== 3'd0) begin errs++; $display("FAIL bp_drain_timeout: got occ=%0d, expected 0", a_occ); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive_a(1, 20, 32'h20, 1, 21, 32'h21);
    @(negedge clk); drive_a(1, 22, 32'h22, 1, 23, 32'h23);
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0);
    vecs++;
    if (a_occ !== 3'd3) begin errs++; $display("FAIL mid_pre_occ: got %0d, expected 3", a_occ); end
    rst = 1'b1;
    #1;
    vecs += 4;
    if (a_occ !== 3'd0) begin errs++; $display("FAIL mid_occ: got %0d, expected 0", a_occ); end
    if (a_rf_we !== 1'b0) begin errs++; $display("FAIL mid_we: got %b, expected 0", a_rf_we); end
    if (a_pend !== 32'h0) begin errs++; $display("FAIL mid_pend: got %h, expected 0", a_pend); end
    if (a_in_ready !== 1'b1) begin errs++; $display("FAIL mid_ready: got %b, expected 1", a_in_ready); end
    qa.delete();
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (a_rf_we !== 1'b0) begin errs++; $display("FAIL mid_post_we: got %b, expected 0", a_rf_we); end
    end
  endtask

  task automatic test_waw();
    @(negedge clk);
    b_in_valid = 2'b11; b_in_rd = {5'd7, 5'd7}; b_in_data = {32'h2, 32'h1};
    qb.push_back('{a: 5'd7, d: 32'h2});
    @(negedge clk);
    b_in_valid = 2'b00;
    vecs += 3;
    if (b_rf_we !== 2'b10) begin errs++; $display("FAIL waw_we: got %b, expected 10", b_rf_we); end
    if (b_rf_waddr[1] !== 5'd7 || b_rf_wdata[1] !== 32'h2) begin errs++; $display("FAIL waw_port1: got addr=%0d data=%h, expected 7/2", b_rf_waddr[1], b_rf_wdata[1]); end
    if (b_occ !== 3'd2) begin errs++; $display("FAIL waw_occ: got %0d, expected 2", b_occ); end
    @(negedge clk);
    vecs++;
    if (b_occ !== 3'd0 || b_rf_we !== 2'b00) begin errs++; $display("FAIL waw_after: got occ=%0d we=%b, expected 0/00", b_occ, b_rf_we); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    b_in_valid = 2'b01; b_in_rd = {5'd0, 5'd3}; b_in_data = {32'h0, 32'h33};
    qb.push_back('{a: 5'd3, d: 32'h33});
    @(negedge clk);
    vecs += 3;
    if (b_occ !== 3'd1) begin errs++; $display("FAIL b2b_occ1: got %0d, expected 1", b_occ); end
    if (b_rf_we !== 2'b01) begin errs++; $display("FAIL b2b_we1: got %b, expected 01", b_rf_we); end
    if (b_in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b, expected 1", b_in_ready); end
    b_in_valid = 2'b11; b_in_rd = {5'd11, 5'd10}; b_in_data = {32'h11, 32'h10};
    qb.push_back('{a: 5'd10, d: 32'h10});
    qb.push_back('{a: 5'd11, d: 32'h11});
    @(negedge clk);
    b_in_valid = 2'b00;
    vecs += 3;
    if (b_occ !== 3'd2) begin errs++; $display("FAIL b2b_occ2: got %0d, expected 2", b_occ); end
    if (b_rf_we !== 2'b11) begin errs++; $display("FAIL b2b_we2: got %b, expected 11", b_rf_we); end
    if (b_rf_waddr[0] !== 5'd10 || b_rf_waddr[1] !== 5'd11) begin errs++; $display("FAIL b2b_order: got %0d,%0d, expected 10,11", b_rf_waddr[0], b_rf_waddr[1]); end
    @(negedge clk);
    vecs++;
    if (b_occ !== 3'd0 || b_rf_we !== 2'b00) begin errs++; $display("FAIL b2b_after: got occ=%0d we=%b, expected 0/00", b_occ, b_rf_we); end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b1;
    a_in_valid = '0; a_in_rd = '0; a_in_data = '0;
    b_in_valid = '0; b_in_rd = '0; b_in_data = '0;
    test_reset();
    test_pair();
    test_x0_discard();
    test_back_pressure();
    test_reset_mid();
    test_waw();
    test_back_to_back();
    @(negedge clk);
    vecs += 2;
    if (qa.size() != 0) begin errs++; $display("FAIL a_leftover: got %0d pending writes, expected 0", qa.size()); end
    if (qb.size() != 0) begin errs++; $display("FAIL b_leftover: got %0d pending writes, expected 0", qb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
